// File: rtl/dsi_lane_rx.sv
// dsi_lane_rx -- receive side of one DSI data lane.
//
// Watches the filtered LP pair for the LP-11 -> LP-01 -> LP-00 HS-entry
// sequence, enables HS termination, locks byte alignment on the sync
// pattern and delivers payload bytes. The last TRAIL_BYTES aligned bytes
// of a burst are held back in a delay line and dropped on the return to
// LP-11, so the HS trailer never reaches the packet layer.
//
// Ports:
//   clk_base    byte clock, all logic on its rising edge
//   reset       synchronous reset, active-high
//   lp_in_p/n   LP receiver outputs (already synchronized)
//   hs_data_in  deserializer byte, arbitrary bit alignment, bit 0 earliest
//   hs_term_en  HS termination / receiver enable
//   data_out    aligned payload byte (0 when data_valid is low)
//   data_valid  data_out valid this cycle
//   sof         first data_valid of a burst
//   eof         one-cycle pulse after the last output byte of a burst
//   active      high in every state except RX_STOP
//   sync_err    sync timeout or illegal LP sequence, held until LP-11
//   lp_state    filtered LP state {n,p}
module dsi_lane_rx #(
   parameter logic [7:0] SYNC_PATTERN = 8'b00011101,
   parameter int         LP_FILTER    = 2,
   parameter int         HS_SETTLE    = 3,
   parameter int         SYNC_TIMEOUT = 32,
   parameter int         TRAIL_BYTES  = 2
) (
   input  logic       clk_base,
   input  logic       reset,
   input  logic       lp_in_p,
   input  logic       lp_in_n,
   input  logic [7:0] hs_data_in,
   output logic       hs_term_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       sof,
   output logic       eof,
   output logic       active,
   output logic       sync_err,
   output logic [1:0] lp_state
);

   typedef enum logic [2:0] {
      RX_STOP, RX_HS_RQST, RX_HS_PRPR, RX_HS_SYNC, RX_HS_DATA, RX_ESC, RX_ERROR
   } rx_state_e;

   localparam logic [1:0] LP00 = 2'b00;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP10 = 2'b10;
   localparam logic [1:0] LP11 = 2'b11;

   rx_state_e state_q, state_d;

   logic [1:0] cand_q, cand_d;
   logic [3:0] flt_cnt_q, flt_cnt_d;
   logic [1:0] lp_state_q, lp_state_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] prev_byte_q, prev_byte_d;
   logic [2:0] offset_q, offset_d;
   logic [TRAIL_BYTES-1:0][7:0] dl_q, dl_d;
   logic [2:0] dl_cnt_q, dl_cnt_d;
   logic       seen_q, seen_d;

   logic [1:0]  lp_raw;
   logic [15:0] win;
   logic        match;
   logic [2:0]  match_off;
   logic [7:0]  aligned;
   logic        shift_en;
   logic        dl_full;

   assign lp_raw = {lp_in_n, lp_in_p};
   assign win    = {hs_data_in, prev_byte_q};

   // LP glitch filter: a new raw value restarts the count; the filtered
   // state follows once the raw value has been seen LP_FILTER cycles in a row.
   always_comb begin
      cand_d     = cand_q;
      flt_cnt_d  = flt_cnt_q;
      lp_state_d = lp_state_q;
      if (lp_raw != cand_q) begin
         cand_d    = lp_raw;
         flt_cnt_d = 4'd1;
      end else if (flt_cnt_q < 4'(LP_FILTER)) begin
         flt_cnt_d = flt_cnt_q + 4'd1;
      end
      if (flt_cnt_d >= 4'(LP_FILTER))
         lp_state_d = cand_d;
   end

   // Sync search; scanning downward lets the lowest matching offset win.
   always_comb begin
      match     = 1'b0;
      match_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (win[k +: 8] == SYNC_PATTERN) begin
            match     = 1'b1;
            match_off = 3'(k);
         end
      end
   end

   assign aligned  = win[offset_q +: 8];
   assign shift_en = (state_q == RX_HS_DATA) && (lp_state_q != LP11);
   assign dl_full  = (dl_cnt_q == 3'(TRAIL_BYTES));

   // ---------------- state register ----------------
   always_ff @(posedge clk_base) begin
      if (reset) state_q <= RX_STOP;
      else       state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_STOP: begin
            if      (lp_state_q == LP01) state_d = RX_HS_RQST;
            else if (lp_state_q == LP10) state_d = RX_ESC;
            else if (lp_state_q == LP00) state_d = RX_ERROR;
         end
         RX_HS_RQST: begin
            if      (lp_state_q == LP00) state_d = RX_HS_PRPR;
            else if (lp_state_q == LP11) state_d = RX_STOP;
            else if (lp_state_q == LP10) state_d = RX_ERROR;
         end
         RX_HS_PRPR: begin
            if      (lp_state_q != LP00)              state_d = RX_ERROR;
            else if (timer_q == 8'(HS_SETTLE - 1))    state_d = RX_HS_SYNC;
         end
         RX_HS_SYNC: begin
            // Lane dropping back to stop before sync simply ends the burst.
            if      (lp_state_q == LP11)              state_d = RX_STOP;
            else if (lp_state_q != LP00)              state_d = RX_ERROR;
            else if (match)                           state_d = RX_HS_DATA;
            else if (timer_q == 8'(SYNC_TIMEOUT - 1)) state_d = RX_ERROR;
         end
         RX_HS_DATA: if (lp_state_q == LP11) state_d = RX_STOP;
         RX_ESC:     if (lp_state_q == LP11) state_d = RX_STOP;
         RX_ERROR:   if (lp_state_q == LP11) state_d = RX_STOP;
         default:    state_d = RX_STOP;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      hs_term_en = (state_q == RX_HS_PRPR) || (state_q == RX_HS_SYNC) ||
                   (state_q == RX_HS_DATA);
      active     = (state_q != RX_STOP);
      sync_err   = (state_q == RX_ERROR);
      data_valid = shift_en && dl_full;
      data_out   = data_valid ? dl_q[TRAIL_BYTES-1] : 8'd0;
      sof        = data_valid && !seen_q;
      eof        = (state_q == RX_HS_DATA) && (lp_state_q == LP11) && seen_q;
      lp_state   = lp_state_q;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      prev_byte_d = hs_data_in;
      // One timer serves both the settle count and the sync timeout; it
      // restarts on every state change.
      timer_d     = (state_d == state_q) ? timer_q + 8'd1 : 8'd0;
      offset_d    = (state_q == RX_HS_SYNC && match) ? match_off : offset_q;
      dl_d        = dl_q;
      dl_cnt_d    = dl_cnt_q;
      if (shift_en) begin
         dl_d[0] = aligned;
         for (int i = 1; i < TRAIL_BYTES; i++) dl_d[i] = dl_q[i-1];
         if (!dl_full) dl_cnt_d = dl_cnt_q + 3'd1;
      end else if (state_q != RX_HS_DATA) begin
         dl_cnt_d = 3'd0;   // flush: held trailer bytes are never output
      end
      seen_d = (state_q != RX_HS_DATA) ? 1'b0 : (seen_q || data_valid);
   end

   always_ff @(posedge clk_base) begin
      if (reset) begin
         cand_q      <= LP11;
         flt_cnt_q   <= 4'd0;
         lp_state_q  <= LP11;
         timer_q     <= 8'd0;
         prev_byte_q <= 8'd0;
         offset_q    <= 3'd0;
         dl_q        <= '0;
         dl_cnt_q    <= 3'd0;
         seen_q      <= 1'b0;
      end else begin
         cand_q      <= cand_d;
         flt_cnt_q   <= flt_cnt_d;
         lp_state_q  <= lp_state_d;
         timer_q     <= timer_d;
         prev_byte_q <= prev_byte_d;
         offset_q    <= offset_d;
         dl_q        <= dl_d;
         dl_cnt_q    <= dl_cnt_d;
         seen_q      <= seen_d;
      end
   end

endmodule

// File: tb/tb_dsi_lane_rx.sv
// Testbench for dsi_lane_rx: table-driven clean burst (offset 0 and 5),
// plus hand-written glitch, sync-timeout, dummy-burst and reset sequences.
module tb_dsi_lane_rx;

   logic       clk_base = 1'b0;
   logic       reset;
   logic       lp_in_p, lp_in_n;
   logic [7:0] hs_data_in;
   logic       hs_term_en, data_valid, sof, eof, active, sync_err;
   logic [7:0] data_out;
   logic [1:0] lp_state;

   dsi_lane_rx dut (
      .clk_base  (clk_base),
      .reset     (reset),
      .lp_in_p   (lp_in_p),
      .lp_in_n   (lp_in_n),
      .hs_data_in(hs_data_in),
      .hs_term_en(hs_term_en),
      .data_out  (data_out),
      .data_valid(data_valid),
      .sof       (sof),
      .eof       (eof),
      .active    (active),
      .sync_err  (sync_err),
      .lp_state  (lp_state)
   );

   always #5 clk_base = ~clk_base;

   typedef struct {
      logic [1:0] lp;     // raw {n,p} driven this cycle
      logic [7:0] hs;     // unshifted wire byte this cycle
      logic [1:0] e_lp;
      logic       e_act, e_term, e_vld;
      logic [7:0] e_data;
      logic       e_sof, e_eof, e_err;
   } vec_t;

   localparam int NROWS = 22;
   vec_t tbl [NROWS];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk_base);
      #1;
   endtask

   function automatic logic [15:0] obs;
      return {lp_state, active, hs_term_en, data_valid, data_out, sof, eof, sync_err};
   endfunction

   task automatic row(input int i, input logic [1:0] lp, input logic [7:0] hs,
                      input logic [1:0] elp, input logic act, input logic term,
                      input logic vld, input logic [7:0] d, input logic s,
                      input logic e, input logic err);
      tbl[i] = '{lp, hs, elp, act, term, vld, d, s, e, err};
   endtask

   task automatic drive_lp(input logic [1:0] v);
      lp_in_n = v[1];
      lp_in_p = v[0];
   endtask

   // Run table rows 0..last with the wire stream delayed by s bits.
   task automatic run_rows(input int s, input int last);
      logic [7:0]  prev;
      logic [15:0] pair;
      logic [15:0] ex;
      prev = 8'h00;
      for (int t = 0; t <= last; t++) begin
         pair = {tbl[t].hs, prev} >> (8 - s);
         prev = tbl[t].hs;
         drive_lp(tbl[t].lp);
         hs_data_in = pair[7:0];
         ex = {tbl[t].e_lp, tbl[t].e_act, tbl[t].e_term, tbl[t].e_vld,
               tbl[t].e_data, tbl[t].e_sof, tbl[t].e_eof, tbl[t].e_err};
         chk($sformatf("burst_s%0d_t%0d", s, t), 32'(obs()), 32'(ex));
         tick();
      end
   endtask

   // LP-01 for 4 cycles, then LP-00 from j=0 with the given stream;
   // raw LP-11 from cycle lp11_at on.
   logic [7:0] stream [64];

   initial begin
      logic bad;

      //      t   lp     hs     elp   act  term vld  data  sof eof err
      row( 0, 2'b01, 8'h00, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);
      row( 1, 2'b01, 8'h00, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);
      row( 2, 2'b01, 8'h00, 2'b01, 0, 0, 0, 8'h00, 0, 0, 0);
      row( 3, 2'b01, 8'h00, 2'b01, 1, 0, 0, 8'h00, 0, 0, 0);
      row( 4, 2'b00, 8'h00, 2'b01, 1, 0, 0, 8'h00, 0, 0, 0);
      row( 5, 2'b00, 8'h00, 2'b01, 1, 0, 0, 8'h00, 0, 0, 0);
      row( 6, 2'b00, 8'h00, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0);
      row( 7, 2'b00, 8'h00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row( 8, 2'b00, 8'h00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row( 9, 2'b00, 8'h00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(10, 2'b00, 8'h00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(11, 2'b00, 8'h00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(12, 2'b00, 8'h1D, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(13, 2'b00, 8'hA5, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(14, 2'b00, 8'h3C, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(15, 2'b00, 8'h81, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0);
      row(16, 2'b00, 8'hFF, 2'b00, 1, 1, 1, 8'hA5, 1, 0, 0);
      row(17, 2'b11, 8'hFF, 2'b00, 1, 1, 1, 8'h3C, 0, 0, 0);
      row(18, 2'b11, 8'h00, 2'b00, 1, 1, 1, 8'h81, 0, 0, 0);
      row(19, 2'b11, 8'h00, 2'b11, 1, 1, 0, 8'h00, 0, 1, 0);
      row(20, 2'b11, 8'h00, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);
      row(21, 2'b11, 8'h00, 2'b11, 0, 0, 0, 8'h00, 0, 0, 0);

      reset = 1'b1;
      drive_lp(2'b11);
      hs_data_in = 8'h00;
      repeat (3) tick();
      chk("reset_state", 32'(obs()), 32'h0000_C000);
      reset = 1'b0;
      repeat (3) tick();
      chk("idle_stop", 32'(obs()), 32'h0000_C000);

      // Clean burst, sync at offset 0.
      run_rows(0, NROWS - 1);
      chk("offset_0", 32'(dut.offset_q), 32'd0);
      repeat (2) tick();

      // Same burst delayed by 5 bits.
      run_rows(5, NROWS - 1);
      chk("offset_5", 32'(dut.offset_q), 32'd5);
      repeat (2) tick();

      // Glitch rejection: single-cycle LP-01 pulse.
      drive_lp(2'b01);
      tick();
      drive_lp(2'b11);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("glitch_%0d", i), 32'({lp_state, active, hs_term_en}), 32'b11_0_0);
         tick();
      end

      // Sync timeout: search starts at j=6, error after 32 search cycles.
      drive_lp(2'b01);
      repeat (4) tick();
      for (int j = 0; j < 46; j++) begin
         drive_lp(2'b00);
         hs_data_in = 8'h00;
         if (j == 37) chk("tmo_last_search", 32'({active, hs_term_en, sync_err}), 32'b110);
         if (j == 38) chk("tmo_error",       32'({active, hs_term_en, sync_err}), 32'b101);
         if (j == 45) chk("tmo_sticky",      32'({active, hs_term_en, sync_err}), 32'b101);
         tick();
      end
      drive_lp(2'b11);
      tick();
      tick();
      chk("tmo_err_held", 32'({lp_state, sync_err}), 32'b11_1);
      tick();
      chk("tmo_cleared", 32'({active, sync_err}), 32'b00);
      repeat (2) tick();

      // Dummy burst: sync then exactly TRAIL_BYTES bytes.
      for (int j = 0; j < 64; j++) stream[j] = 8'h00;
      stream[8] = 8'h1D; stream[9] = 8'hFF; stream[10] = 8'hFF;
      drive_lp(2'b01);
      repeat (4) tick();
      bad = 1'b0;
      for (int j = 0; j < 16; j++) begin
         drive_lp((j >= 10) ? 2'b11 : 2'b00);
         hs_data_in = stream[j];
         if (j == 11) chk("dummy_in_data", 32'({active, hs_term_en}), 32'b11);
         if (data_valid || sof || eof) bad = 1'b1;
         tick();
      end
      chk("dummy_no_output", 32'(bad), 32'd0);
      chk("dummy_stop", 32'(obs()), 32'h0000_C000);

      // Reset mid-burst after two output bytes.
      run_rows(0, 17);
      reset = 1'b1;
      drive_lp(2'b11);
      hs_data_in = 8'h00;
      tick();
      reset = 1'b0;
      chk("midrst_outputs", 32'(obs()), 32'h0000_C000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("midrst_after_%0d", i), 32'(obs()), 32'h0000_C000);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
